// File: rtl/pdm_if.sv
// Sample stream into the PDM modulator and its bitstream/status outputs.
// The master side is the PCM source; the slave side is pdm_modulator.
interface pdm_if;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               sample_ready;
    logic               pdm_out;
    logic               sample_tick;
    logic               underrun;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready,
        input  pdm_out,
        input  sample_tick,
        input  underrun
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready,
        output pdm_out,
        output sample_tick,
        output underrun
    );
endinterface

// File: rtl/pdm_modulator.sv
// Second-order sigma-delta modulator: 16-bit signed PCM in, 1-bit PDM out, OSR bits per sample.
// Define PDM_DITHER_EN to add +/-1 LFSR dither at the quantizer.
module pdm_modulator #(
    parameter int unsigned OSR  = 128,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    pdm_if.slave bus
);
    localparam int unsigned   CW       = $clog2(OSR);
    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic signed [21:0] i1_r;
    logic signed [27:0] i2_r;
    logic signed [15:0] cur_r;
    logic signed [15:0] nxt_r;
    logic               full_r;
    logic               pdm_out_r;
    logic               tick_r;
    logic               underrun_r;

    logic               hs_s;
    logic               bnd_s;
    logic               take_s;
    logic signed [16:0] fb_s;
    logic signed [23:0] sum1_s;
    logic signed [29:0] sum2_s;
    logic signed [21:0] i1_nxt_s;
    logic signed [27:0] i2_nxt_s;
    logic               q_s;

    // A zero seed would lock the dither LFSR in the all-zero state.
    if (SEED == 16'h0000) begin : g_seed_zero
        $error("pdm_modulator: SEED must be non-zero");
    end

    function automatic logic signed [21:0] sat22(input logic signed [23:0] v);
        logic signed [21:0] r;
        if (v > 24'sd2097151)       r = {1'b0, {21{1'b1}}};
        else if (v < -24'sd2097152) r = {1'b1, {21{1'b0}}};
        else                        r = v[21:0];
        return r;
    endfunction

    function automatic logic signed [27:0] sat28(input logic signed [29:0] v);
        logic signed [27:0] r;
        if (v > 30'sd134217727)       r = {1'b0, {27{1'b1}}};
        else if (v < -30'sd134217728) r = {1'b1, {27{1'b0}}};
        else                          r = v[27:0];
        return r;
    endfunction

    // Loop arithmetic, handshake and boundary decode.
    always_comb begin
        fb_s     = pdm_out_r ? 17'sd32768 : -17'sd32768;
        sum1_s   = 24'(i1_r) + 24'(cur_r) - 24'(fb_s);
        sum2_s   = 30'(i2_r) + 30'(i1_r) - 30'(fb_s);
        i1_nxt_s = sat22(sum1_s);
        i2_nxt_s = sat28(sum2_s);
        hs_s     = bus.sample_valid & ~full_r;
        bnd_s    = (cnt_r == CNT_LAST);
        // Buffer moves to cur on entry to RUN and at every running boundary.
        take_s   = en & full_r & ((state_r == ST_IDLE) | bnd_s);
    end

`ifdef PDM_DITHER_EN
    logic [15:0]        lfsr_r;
    logic signed [1:0]  dith_s;
    logic signed [28:0] qsum_s;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped once per running clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SEED;
        end else if ((state_r == ST_RUN) && en) begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Dithered quantizer.
    always_comb begin
        dith_s = lfsr_r[0] ? 2'sb01 : 2'sb11;
        qsum_s = 29'(i2_nxt_s) + 29'(dith_s);
        q_s    = ~qsum_s[28];
    end
`else
    // Plain quantizer: sign of the second integrator.
    always_comb begin
        q_s = ~i2_nxt_s[27];
    end
`endif

    // Control FSM, input buffer, integrators and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            i1_r       <= '0;
            i2_r       <= '0;
            cur_r      <= '0;
            nxt_r      <= '0;
            full_r     <= 1'b0;
            pdm_out_r  <= 1'b0;
            tick_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            tick_r     <= 1'b0;
            underrun_r <= 1'b0;
            full_r     <= take_s ? 1'b0 : (full_r | hs_s);
            nxt_r      <= hs_s ? bus.sample_in : nxt_r;
            cur_r      <= take_s ? nxt_r : cur_r;
            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= '0;
                    i1_r      <= '0;
                    i2_r      <= '0;
                    pdm_out_r <= ~pdm_out_r;
                    if (take_s) begin
                        state_r <= ST_RUN;
                        tick_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_r   <= ST_IDLE;
                        cnt_r     <= '0;
                        i1_r      <= '0;
                        i2_r      <= '0;
                        pdm_out_r <= 1'b0;
                    end else begin
                        state_r    <= ST_RUN;
                        cnt_r      <= cnt_r + CW'(1);
                        i1_r       <= i1_nxt_s;
                        i2_r       <= i2_nxt_s;
                        pdm_out_r  <= q_s;
                        tick_r     <= bnd_s;
                        underrun_r <= bnd_s & ~full_r;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= '0;
                    i1_r      <= '0;
                    i2_r      <= '0;
                    pdm_out_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sample_ready = ~full_r;
    assign bus.pdm_out      = pdm_out_r;
    assign bus.sample_tick  = tick_r;
    assign bus.underrun     = underrun_r;
endmodule
